sprite_rom_arbiter: RTL and testbench

SPRITE_ROM_ARBITER -- requirements
Module: sprite_rom_arbiter

---
 rtl/sprite_rom_arbiter.sv | 158 +++++++++++++++
 tb/tb_sprite_rom_arbiter.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_rom_arbiter.sv
// Round-robin arbiter sharing one synchronous sprite ROM among NREQ requesters,
// with burst limiting. Optional stall counter enabled by SPRITE_ARB_STATS_EN.
module sprite_rom_arbiter #(
  parameter int NREQ      = 4,
  parameter int ADDRW     = 11,
  parameter int COLR_BITS = 8,
  parameter int MAX_BURST = 38
) (
  input  logic                  i_clk_pix,
  input  logic                  i_rst_n,
  input  logic                  i_frame,
  input  logic [NREQ-1:0]       i_req,
  input  logic [NREQ*ADDRW-1:0] i_addr,
  output logic [NREQ-1:0]       o_gnt,
  output logic [ADDRW-1:0]      o_rom_addr,
  input  logic [COLR_BITS-1:0]  i_rom_data,
  output logic [COLR_BITS-1:0]  o_data,
  output logic [NREQ-1:0]       o_valid
`ifdef SPRITE_ARB_STATS_EN
  ,
  output logic [15:0]           o_stall_cnt
`endif
);

  localparam int unsigned IDXW = $clog2(NREQ);
  localparam int unsigned BW   = $clog2(MAX_BURST + 1);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [IDXW-1:0]   owner_q, owner_d;
  logic [IDXW-1:0]   ptr_q, ptr_d;
  logic [BW-1:0]     burst_q, burst_d;
  logic [NREQ-1:0]   valid_q, valid_d;

  state_e            cur_state;
  logic [IDXW-1:0]   cur_owner, cur_ptr, scan_idx, gnt_idx, idx_w;
  logic [BW-1:0]     cur_burst;
  logic              others, own_req, expired, keep, found, gnt_vld;
  int                idx;

  // Grant decision; during reset the arbitration starts from reset values.
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    ptr_d      = ptr_q;
    burst_d    = burst_q;
    gnt_idx    = '0;
    gnt_vld    = 1'b0;
    scan_idx   = '0;
    found      = 1'b0;
    others     = 1'b0;
    own_req    = 1'b0;
    idx        = 0;
    idx_w      = '0;
    o_gnt      = '0;
    o_rom_addr = '0;

    cur_state = i_rst_n ? state_q : IDLE;
    cur_owner = i_rst_n ? owner_q : '0;
    cur_ptr   = i_rst_n ? ptr_q   : '0;
    cur_burst = i_rst_n ? burst_q : '0;

    for (int k = 0; k < NREQ; k++) begin
      if (cur_owner == IDXW'(k)) own_req = i_req[k];
      else if (i_req[k])         others  = 1'b1;
    end

    expired = (cur_state == HOLD) && (cur_burst >= BW'(MAX_BURST));
    keep    = (cur_state == HOLD) && own_req &&
              ((cur_burst < BW'(MAX_BURST)) || !others);

    for (int i = 0; i < NREQ; i++) begin
      idx = int'(cur_ptr) + i;
      if (idx >= NREQ) idx = idx - NREQ;
      idx_w = IDXW'(idx);
      if (!found && i_req[idx_w] && !(expired && idx_w == cur_owner)) begin
        found    = 1'b1;
        scan_idx = idx_w;
      end
    end

    if (keep) begin
      gnt_idx = cur_owner;
      gnt_vld = 1'b1;
      if (cur_burst < BW'(MAX_BURST)) burst_d = cur_burst + BW'(1);
      else                            burst_d = cur_burst;
    end else if (|i_req) begin
      // An expired owner that is the sole requester is re-granted.
      gnt_idx = found ? scan_idx : cur_owner;
      gnt_vld = 1'b1;
      state_d = HOLD;
      owner_d = gnt_idx;
      burst_d = BW'(1);
      ptr_d   = (gnt_idx == IDXW'(NREQ - 1)) ? '0 : gnt_idx + IDXW'(1);
    end else begin
      state_d = IDLE;
      burst_d = '0;
    end

    if (i_frame) begin
      ptr_d   = '0;
      burst_d = '0;
    end

    for (int k = 0; k < NREQ; k++) begin
      if (gnt_vld && gnt_idx == IDXW'(k)) begin
        o_gnt[k]   = 1'b1;
        o_rom_addr = i_addr[k*ADDRW +: ADDRW];
      end
    end

    valid_d = o_gnt;
  end

  always_ff @(posedge i_clk_pix) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      owner_q <= '0;
      ptr_q   <= '0;
      burst_q <= '0;
      valid_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      burst_q <= burst_d;
      valid_q <= valid_d;
    end
  end

  assign o_valid = valid_q;
  assign o_data  = i_rom_data;

`ifdef SPRITE_ARB_STATS_EN
  logic [15:0] stall_q, stall_d;

  // Counts cycles where some asserted request went ungranted.
  always_comb begin
    stall_d = stall_q;
    if (i_frame)
      stall_d = '0;
    else if ((|(i_req & ~o_gnt)) && (stall_q != 16'hFFFF))
      stall_d = stall_q + 16'd1;
  end

  always_ff @(posedge i_clk_pix) begin
    if (!i_rst_n) stall_q <= '0;
    else          stall_q <= stall_d;
  end

  assign o_stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Randomized and directed bench for sprite_rom_arbiter against a behavioural model.
// Define SPRITE_ARB_STATS_EN to also exercise the stall counter.
module tb_sprite_rom_arbiter;

  localparam int NREQ  = 4;
  localparam int ADDRW = 11;
  localparam int CB    = 8;
  localparam int MAXB  = 38;

  logic                  clk = 1'b0;
  logic                  i_rst_n;
  logic                  i_frame;
  logic [NREQ-1:0]       i_req;
  logic [NREQ*ADDRW-1:0] i_addr;
  logic [NREQ-1:0]       o_gnt;
  logic [ADDRW-1:0]      o_rom_addr;
  logic [CB-1:0]         i_rom_data;
  logic [CB-1:0]         o_data;
  logic [NREQ-1:0]       o_valid;
`ifdef SPRITE_ARB_STATS_EN
  logic [15:0]           o_stall_cnt;
`endif

  sprite_rom_arbiter #(
    .NREQ(NREQ), .ADDRW(ADDRW), .COLR_BITS(CB), .MAX_BURST(MAXB)
  ) dut (
    .i_clk_pix (clk),
    .i_rst_n   (i_rst_n),
    .i_frame   (i_frame),
    .i_req     (i_req),
    .i_addr    (i_addr),
    .o_gnt     (o_gnt),
    .o_rom_addr(o_rom_addr),
    .i_rom_data(i_rom_data),
    .o_data    (o_data),
    .o_valid   (o_valid)
`ifdef SPRITE_ARB_STATS_EN
    ,
    .o_stall_cnt(o_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model state
  int        m_hold, m_owner, m_ptr, m_burst, m_stall;
  logic [3:0] m_valid;
  logic [3:0] obs_gnt, obs_valid;
  logic [10:0] obs_addr;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [43:0] rand_addr();
    return 44'({$urandom(), $urandom()});
  endfunction

  // kind: 0 = no grant, 1 = owner kept, 2 = new grant
  function automatic int pick(input logic [3:0] req, input logic rst_n, output int kind);
    int hold, own, ptr, bur, idx;
    hold = rst_n ? m_hold  : 0;
    own  = rst_n ? m_owner : 0;
    ptr  = rst_n ? m_ptr   : 0;
    bur  = rst_n ? m_burst : 0;
    kind = 2;
    if (req == 4'b0) begin
      kind = 0;
      return -1;
    end
    if (hold != 0 && req[own] && (bur < MAXB || (req & ~(4'b0001 << own)) == 4'b0)) begin
      kind = 1;
      return own;
    end
    for (int i = 0; i < NREQ; i++) begin
      idx = (ptr + i) % NREQ;
      if (req[idx] && !(hold != 0 && bur >= MAXB && idx == own)) return idx;
    end
    return own;
  endfunction

  task automatic model_reset();
    m_hold = 0; m_owner = 0; m_ptr = 0; m_burst = 0; m_stall = 0; m_valid = '0;
  endtask

  task automatic step(input logic [3:0] req, input logic frame, input logic rst_n,
                      input logic [43:0] addr);
    int g, kind;
    logic [3:0] eg;
    logic [10:0] ea;
    logic stall;
    i_req      = req;
    i_frame    = frame;
    i_rst_n    = rst_n;
    i_addr     = addr;
    i_rom_data = 8'($urandom);
    @(negedge clk);
    g  = pick(req, rst_n, kind);
    eg = (g < 0) ? 4'b0 : 4'(4'b0001 << g);
    ea = (g < 0) ? 11'd0 : 11'(addr >> (g * ADDRW));
    check("gnt", 32'(o_gnt), 32'(eg));
    check("rom_addr", 32'(o_rom_addr), 32'(ea));
    check("valid", 32'(o_valid), 32'(m_valid));
    check("data", 32'(o_data), 32'(i_rom_data));
`ifdef SPRITE_ARB_STATS_EN
    check("stall_cnt", 32'(o_stall_cnt), 32'(m_stall));
`endif
    obs_gnt   = o_gnt;
    obs_addr  = o_rom_addr;
    obs_valid = o_valid;
    stall     = (req & ~eg) != 4'b0;
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
    end else begin
      m_valid = eg;
      case (kind)
        1: if (m_burst < MAXB) m_burst++;
        2: begin m_owner = g; m_hold = 1; m_burst = 1; m_ptr = (g + 1) % NREQ; end
        default: begin m_hold = 0; m_burst = 0; end
      endcase
      if (frame) begin
        m_ptr = 0; m_burst = 0; m_stall = 0;
      end else if (stall && m_stall < 65535) begin
        m_stall++;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    repeat (2) step(4'($urandom), 1'b0, 1'b0, rand_addr());
  endtask

  initial begin
    logic [43:0] a;
    logic [3:0]  r;
    i_rst_n = 1'b0; i_frame = 1'b0; i_req = '0; i_addr = '0; i_rom_data = '0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();

    // Reset-cycle grants, then a single read
    do_reset();
    a = rand_addr();
    a[10:0] = 11'd5;
    step(4'b0001, 1'b0, 1'b1, a);
    check("single_gnt", 32'(obs_gnt), 32'h1);
    check("single_addr", 32'(obs_addr), 32'd5);
    step(4'b0000, 1'b0, 1'b1, rand_addr());
    check("single_valid", 32'(obs_valid), 32'h1);

    // All four held: 38-cycle bursts rotating 0,1,2,3,0
    do_reset();
    for (int c = 0; c < 4 * MAXB + 1; c++) begin
      step(4'b1111, 1'b0, 1'b1, rand_addr());
      check("rotate", 32'(obs_gnt), 32'(4'b0001 << ((c / MAXB) % 4)));
    end

    // Owner 1 drops while 2 waits
    do_reset();
    step(4'b0010, 1'b0, 1'b1, rand_addr());
    repeat (2) step(4'b0110, 1'b0, 1'b1, rand_addr());
    step(4'b0100, 1'b0, 1'b1, rand_addr());
    check("drop", 32'(obs_gnt), 32'h4);
    for (int c = 0; c < MAXB - 1; c++) begin
      step(4'b0110, 1'b0, 1'b1, rand_addr());
      check("drop_burst", 32'(obs_gnt), 32'h4);
    end
    step(4'b0110, 1'b0, 1'b1, rand_addr());
    check("drop_rotate", 32'(obs_gnt), 32'h2);

    // Lone requester never rotates
    do_reset();
    for (int c = 0; c < 100; c++) begin
      step(4'b1000, 1'b0, 1'b1, rand_addr());
      check("lone", 32'(obs_gnt), 32'h8);
    end

    // Frame pulse mid-burst of owner 2
    do_reset();
    repeat (2 * MAXB + 10) step(4'b1111, 1'b0, 1'b1, rand_addr());
    check("pre_frame", 32'(obs_gnt), 32'h4);
    step(4'b1111, 1'b1, 1'b1, rand_addr());
    check("frame_cycle", 32'(obs_gnt), 32'h4);
    for (int c = 0; c < MAXB; c++) begin
      step(4'b1111, 1'b0, 1'b1, rand_addr());
      check("frame_hold", 32'(obs_gnt), 32'h4);
    end
    step(4'b1111, 1'b0, 1'b1, rand_addr());
    check("frame_next", 32'(obs_gnt), 32'h1);

`ifdef SPRITE_ARB_STATS_EN
    do_reset();
    repeat (10) step(4'b0011, 1'b0, 1'b1, rand_addr());
    check("stall10", 32'(o_stall_cnt), 32'd10);
    step(4'b0011, 1'b1, 1'b1, rand_addr());
    check("stall_clr", 32'(o_stall_cnt), 32'd0);
`endif

    // Random traffic with occasional frames and resets
    do_reset();
    r = 4'($urandom);
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(3) == 0) r = 4'($urandom);
      step(r, ($urandom_range(63) == 0), ($urandom_range(255) != 0), rand_addr());
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
